// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one match-table memory port between NUM_REQ requesters. A requester
// is granted in round-robin order and keeps the port until it drops its
// chip-enable, so multi-beat transactions are never interleaved. A watchdog
// reclaims the port when a single beat stalls for TIMEOUT cycles. The stalled
// requester is then blocked until it drops its chip-enable.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_ce_i        per-requester chip-enable, held for the whole transaction
//   req_we_i        per-requester write enable
//   req_addr_i      per-requester byte address
//   req_width_i     per-requester access width in bytes
//   req_data_i      per-requester write data
//   req_data_o      read data, mem_data_i broadcast to every requester
//   req_ready_o     per-requester beat complete; only the owner's bit can be high
//   grant_o         one-hot current owner, zero when idle
//   mem_*_o         memory port, driven from the owner's request signals
//   mem_data_i      memory read data
//   mem_ready_i     memory beat complete
//   timeout_o       one-cycle pulse on a forced release
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; round-robin pick among requesters that are not blocked
// BUSY  | owner_q holds the port; leaves on owner ce low or on a beat stall
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_ce_i,
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ-1:0][31:0] req_addr_i,
  input  logic [NUM_REQ-1:0][3:0]  req_width_i,
  input  logic [NUM_REQ-1:0][31:0] req_data_i,
  output logic [31:0]              req_data_o,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     mem_ce_o,
  output logic                     mem_we_o,
  output logic [31:0]              mem_addr_o,
  output logic [3:0]               mem_width_o,
  output logic [31:0]              mem_data_o,
  input  logic [31:0]              mem_data_i,
  input  logic                     mem_ready_i,
  output logic                     timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0] blocked_q, blocked_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_ce;
  logic               owner_active;

  assign eligible     = req_ce_i & ~blocked_q;
  assign owner_ce     = req_ce_i[owner_q];
  // The memory side only sees a request while the owner still asserts ce, so
  // a release drops mem_ce_o in the same cycle and never hands it to anyone else.
  assign owner_active = (state_q == BUSY) && owner_ce;

  // Search starts one past the last owner. A requester that just released
  // is therefore considered last.
  always_comb begin : rr_pick
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_owner_q) + i) % NUM_REQ;
      if (!pick_found && eligible[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = 1'b0;
    // A block lasts only until the requester shows a cycle with ce low.
    blocked_d    = blocked_q & req_ce_i;

    if (state_q == IDLE) begin
      if (pick_found) begin
        state_d           = BUSY;
        owner_d           = pick_idx;
        grant_d           = '0;
        grant_d[pick_idx] = 1'b1;
        wait_cnt_d        = '0;
      end
    end else begin
      if (!owner_ce) begin
        // A normal release wins over a timeout that lands in the same cycle.
        state_d      = IDLE;
        last_owner_d = owner_q;
        grant_d      = '0;
      end else if (!mem_ready_i && (wait_cnt_q == CNT_W'(TIMEOUT))) begin
        state_d            = IDLE;
        last_owner_d       = owner_q;
        grant_d            = '0;
        blocked_d[owner_q] = 1'b1;
        timeout_d          = 1'b1;
      end else if (mem_ready_i) begin
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      blocked_q    <= '0;
      grant_q      <= '0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      blocked_q    <= blocked_d;
      grant_q      <= grant_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant_o     = grant_q;
  assign timeout_o   = timeout_q;
  assign req_data_o  = mem_data_i;
  assign req_ready_o = (owner_active && mem_ready_i) ? grant_q : '0;

  assign mem_ce_o    = owner_active;
  assign mem_we_o    = owner_active && req_we_i[owner_q];
  assign mem_addr_o  = owner_active ? req_addr_i[owner_q]  : '0;
  assign mem_width_o = owner_active ? req_width_i[owner_q] : '0;
  assign mem_data_o  = owner_active ? req_data_i[owner_q]  : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       ce = 4'b0000;
  logic [3:0]       we = 4'b1010;
  logic [3:0][31:0] addr;
  logic [3:0][3:0]  width;
  logic [3:0][31:0] wdata;
  logic [31:0]      mem_rdata = 32'h0;
  logic             mem_ready = 1'b0;

  logic [31:0] req_data_o;
  logic [3:0]  req_ready_o;
  logic [3:0]  grant_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_width_o;
  logic [31:0] mem_data_o;
  logic        timeout_o;

  int passes = 0;
  int total  = 0;

  typedef struct {
    logic [3:0]  grant;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   to_q[$];
  logic [3:0] prev_grant = 4'b0000;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_ce_i   (ce),
    .req_we_i   (we),
    .req_addr_i (addr),
    .req_width_i(width),
    .req_data_i (wdata),
    .req_data_o (req_data_o),
    .req_ready_o(req_ready_o),
    .grant_o    (grant_o),
    .mem_ce_o   (mem_ce_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_width_o(mem_width_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_rdata),
    .mem_ready_i(mem_ready),
    .timeout_o  (timeout_o)
  );

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_grant(input int i);
    exp_t e;
    e.grant = 4'b0001 << i;
    e.addr  = addr_of(i);
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every new grant and every timeout pulse must match
  // the next expectation queued by the stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      if (grant_o != 4'b0000 && prev_grant == 4'b0000) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL grant_unexpected: got %b expected none", grant_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("grant_order", 32'(grant_o), 32'(e.grant));
          chk("grant_addr", mem_addr_o, e.addr);
        end
      end
      if (timeout_o) begin
        if (to_q.size() == 0) begin
          total++;
          $display("FAIL timeout_unexpected: got 1 expected 0");
        end else begin
          void'(to_q.pop_front());
          chk("timeout_idle", 32'(grant_o), 32'h0);
        end
      end
    end
    prev_grant = grant_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner idx is granted on entry. Give it some ready beats, release it, and
  // check the dead cycle and the following owner.
  task automatic serve(input int idx, input int beats, input bit reraise, input logic [3:0] nxt);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    for (int b = 0; b < beats; b++) begin
      tick();
      mem_ready = 1'b1;
      @(negedge clk);
      chk("beat_ready", 32'(req_ready_o), 32'(oh));
      chk("beat_grant", 32'(grant_o), 32'(oh));
      chk("beat_addr", mem_addr_o, addr_of(idx));
      chk("beat_data", mem_data_o, data_of(idx));
      chk("beat_we", 32'(mem_we_o), 32'(we[idx]));
      chk("beat_width", 32'(mem_width_o), 32'(width[idx]));
    end
    tick();
    mem_ready = 1'b0;
    ce[idx] = 1'b0;
    @(negedge clk);
    chk("release_ce", 32'(mem_ce_o), 32'h0);
    tick();
    if (reraise) ce[idx] = 1'b1;
    @(negedge clk);
    chk("dead_cycle", 32'(grant_o), 32'h0);
    tick();
    @(negedge clk);
    chk("next_grant", 32'(grant_o), 32'(nxt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr[i]  = addr_of(i);
      wdata[i] = data_of(i);
      width[i] = 4'(1 << (i % 3));
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_mem_ce", 32'(mem_ce_o), 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    tick();
    rst = 1'b0;

    // Grant latency, then full rotation 0,1,2,3,0
    tick();
    push_grant(0);
    ce = 4'b1111;
    @(negedge clk);
    chk("latency_pre", 32'(grant_o), 32'h0);
    tick();
    @(negedge clk);
    chk("latency_ce", 32'(mem_ce_o), 32'h1);
    push_grant(1);
    push_grant(2);
    push_grant(3);
    push_grant(0);
    for (int k = 0; k < 4; k++) serve(k, 3, 1'b1, 4'b0001 << ((k + 1) % 4));

    // Transaction lock: requester 1 keeps the port while 0 waits
    push_grant(1);
    tick();
    ce = 4'b0010;
    @(negedge clk);
    chk("lock_release_ce", 32'(mem_ce_o), 32'h0);
    tick();
    ce = 4'b0011;
    @(negedge clk);
    chk("lock_dead", 32'(grant_o), 32'h0);
    tick();
    @(negedge clk);
    chk("lock_grant1", 32'(grant_o), 32'h2);
    push_grant(0);
    serve(1, 6, 1'b0, 4'b0001);

    // Ready routing to requester 2
    push_grant(2);
    tick();
    ce = 4'b0100;
    tick();
    @(negedge clk);
    chk("route_dead", 32'(grant_o), 32'h0);
    tick();
    mem_rdata = 32'hDEADBEEF;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("route_ready", 32'(req_ready_o), 32'h4);
    chk("route_rdata", req_data_o, 32'hDEADBEEF);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("route_ready_low", 32'(req_ready_o), 32'h0);

    // Back-to-back single requester 2
    push_grant(2);
    tick();
    ce = 4'b0000;
    @(negedge clk);
    chk("b2b_release", 32'(mem_ce_o), 32'h0);
    tick();
    ce = 4'b0100;
    @(negedge clk);
    chk("b2b_dead", 32'(grant_o), 32'h0);
    tick();
    @(negedge clk);
    chk("b2b_regrant", 32'(grant_o), 32'h4);

    // Asynchronous reset in the middle of a transaction
    tick();
    mem_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_ce", 32'(mem_ce_o), 32'h0);
    chk("arst_grant", 32'(grant_o), 32'h0);
    chk("arst_ready", 32'(req_ready_o), 32'h0);
    ce = 4'b0000;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    push_grant(0);
    tick();
    ce = 4'b1111;
    @(negedge clk);
    chk("arst_pre", 32'(grant_o), 32'h0);
    tick();
    @(negedge clk);
    chk("arst_grant0", 32'(grant_o), 32'h1);

    // Timeout: owner 3 stalls, requester 0 takes over, 3 stays blocked
    push_grant(3);
    tick();
    ce = 4'b1000;
    tick();
    @(negedge clk);
    chk("to_dead", 32'(grant_o), 32'h0);
    tick();
    @(negedge clk);
    chk("to_grant3", 32'(grant_o), 32'h8);
    to_q.push_back(1);
    push_grant(0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) ce = 4'b1001;
      @(negedge clk);
      if (k == 8) begin
        chk("to_hold", 32'(grant_o), 32'h8);
        chk("to_not_yet", 32'(timeout_o), 32'h0);
      end
    end
    tick();
    @(negedge clk);
    chk("to_pulse", 32'(timeout_o), 32'h1);
    tick();
    @(negedge clk);
    chk("to_one_cycle", 32'(timeout_o), 32'h0);
    chk("to_grant0", 32'(grant_o), 32'h1);
    tick();
    ce = 4'b1000;
    repeat (4) tick();
    @(negedge clk);
    chk("blocked_no_regrant", 32'(grant_o), 32'h0);
    push_grant(3);
    tick();
    ce = 4'b0000;
    tick();
    ce = 4'b1000;
    @(negedge clk);
    chk("unblock_dead", 32'(grant_o), 32'h0);
    tick();
    @(negedge clk);
    chk("unblock_regrant", 32'(grant_o), 32'h8);
    tick();
    ce = 4'b0000;
    repeat (3) tick();

    chk("grant_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("timeout_queue_drained", 32'(to_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
